// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game sequencer:
// state encodings, serve directions and score width.
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POSITION = 3'd1,
    SERVE    = 3'd2,
    PLAY     = 3'd3,
    POINT    = 3'd4,
    END      = 3'd5,
    PAUSE    = 3'd6
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/pong_tick_gen.sv
// Divides frame_start pulses into game ticks.
// tick is combinational: high in the frame_start cycle that wraps the count.
module pong_tick_gen #(
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

  logic [7:0] r_frame_cnt;
  logic       w_wrap;

  assign w_wrap = (r_frame_cnt == LAST);
  assign tick   = frame_start & w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (frame_start) begin
      r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong game sequencer with req/done update handshake.
// Optional pause in PLAY enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN         = 4,
  parameter int unsigned FRAME_DIV   = 1,
  parameter int unsigned SERVE_DELAY = 30,
  parameter int unsigned END_HOLD    = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               center,
  input  logic               upd_done,
  input  logic               coll_l,
  input  logic               coll_r,
  output logic               upd_req,
  output logic               pos_req,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               winner
);

  localparam logic [SCORE_W:0] WIN_V = (SCORE_W+1)'(WIN);
  localparam logic [15:0]      SD_V  = 16'(SERVE_DELAY);
  localparam logic [15:0]      EH_V  = 16'(END_HOLD);

  logic w_tick;

  pong_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .tick       (w_tick)
  );

  state_e             r_state, w_state_n;
  logic [2:0]         r_state_o, w_state_o_n;
  logic               r_upd_req, w_upd_req_n;
  logic               r_pos_req, w_pos_req_n;
  logic               r_dir, w_dir_n;
  logic [SCORE_W-1:0] r_score_l, w_score_l_n;
  logic [SCORE_W-1:0] r_score_r, w_score_r_n;
  logic               r_winner, w_winner_n;
  logic [15:0]        r_serve_cnt, w_serve_cnt_n;
  logic [15:0]        r_end_cnt, w_end_cnt_n;
  logic               r_coll_r, w_coll_r_n;
  logic               r_center_q;
  logic               r_pause, w_pause_n;

  logic             w_rise;
  logic             w_done;
  logic             w_paused;
  logic [SCORE_W:0] w_inc_l;
  logic [SCORE_W:0] w_inc_r;

  assign w_rise  = center & ~r_center_q;
  assign w_done  = r_upd_req & upd_done;
  assign w_inc_l = {1'b0, r_score_l} + (SCORE_W+1)'(1);
  assign w_inc_r = {1'b0, r_score_r} + (SCORE_W+1)'(1);

`ifdef PONG_PAUSE_EN
  assign w_paused = r_pause;
`else
  assign w_paused = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_state_o   <= 3'(IDLE);
      r_upd_req   <= 1'b0;
      r_pos_req   <= 1'b0;
      r_dir       <= DIR_RIGHT;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_winner    <= 1'b0;
      r_serve_cnt <= '0;
      r_end_cnt   <= '0;
      r_coll_r    <= 1'b0;
      r_center_q  <= 1'b0;
      r_pause     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_state_o   <= w_state_o_n;
      r_upd_req   <= w_upd_req_n;
      r_pos_req   <= w_pos_req_n;
      r_dir       <= w_dir_n;
      r_score_l   <= w_score_l_n;
      r_score_r   <= w_score_r_n;
      r_winner    <= w_winner_n;
      r_serve_cnt <= w_serve_cnt_n;
      r_end_cnt   <= w_end_cnt_n;
      r_coll_r    <= w_coll_r_n;
      r_center_q  <= center;
      r_pause     <= w_pause_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_upd_req_n   = r_upd_req;
    w_dir_n       = r_dir;
    w_score_l_n   = r_score_l;
    w_score_r_n   = r_score_r;
    w_winner_n    = r_winner;
    w_serve_cnt_n = r_serve_cnt;
    w_end_cnt_n   = r_end_cnt;
    w_coll_r_n    = r_coll_r;
    w_pause_n     = r_pause;

    case (r_state)
      IDLE: begin
        if (center) begin
          w_score_l_n = '0;
          w_score_r_n = '0;
          w_dir_n     = DIR_RIGHT;
          w_state_n   = POSITION;
        end
      end
      POSITION: begin
        w_serve_cnt_n = '0;
        w_state_n     = (SERVE_DELAY == 0) ? PLAY : SERVE;
      end
      SERVE: begin
        if (r_serve_cnt == SD_V) begin
          w_state_n = PLAY;
        end else if (w_tick) begin
          w_serve_cnt_n = r_serve_cnt + 16'd1;
        end
      end
      PLAY: begin
`ifdef PONG_PAUSE_EN
        if (w_rise) w_pause_n = ~r_pause;
`endif
        if (w_done) begin
          w_upd_req_n = 1'b0;
          if (coll_r | coll_l) begin
            w_coll_r_n = coll_r;
            w_state_n  = POINT;
          end
        end else if (w_tick && !r_upd_req && !w_paused) begin
          w_upd_req_n = 1'b1;
        end
      end
      POINT: begin
        w_state_n = POSITION;
        if (r_coll_r) begin
          w_dir_n = DIR_LEFT;
          if (w_inc_l <= WIN_V) w_score_l_n = w_inc_l[SCORE_W-1:0];
          if (w_inc_l == WIN_V) begin
            w_winner_n  = 1'b0;
            w_end_cnt_n = '0;
            w_state_n   = END;
          end
        end else begin
          w_dir_n = DIR_RIGHT;
          if (w_inc_r <= WIN_V) w_score_r_n = w_inc_r[SCORE_W-1:0];
          if (w_inc_r == WIN_V) begin
            w_winner_n  = 1'b1;
            w_end_cnt_n = '0;
            w_state_n   = END;
          end
        end
      end
      END: begin
        if (w_rise || r_end_cnt == EH_V) begin
          w_state_n = IDLE;
        end else if (w_tick) begin
          w_end_cnt_n = r_end_cnt + 16'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase

    if (w_state_n != PLAY) w_pause_n = 1'b0;
  end

  assign w_pos_req_n = (w_state_n == POSITION);
  assign w_state_o_n = w_pause_n ? 3'(PAUSE) : 3'(w_state_n);

  assign upd_req   = r_upd_req;
  assign pos_req   = r_pos_req;
  assign serve_dir = r_dir;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign state     = r_state_o;
  assign winner    = r_winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
// Pause scenario runs only when PONG_PAUSE_EN is defined.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       center;
  logic       upd_done;
  logic       coll_l;
  logic       coll_r;
  logic       upd_req;
  logic       pos_req;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] state;
  logic       winner;

  int n_chk  = 0;
  int n_fail = 0;

  pong_game_ctrl #(
    .WIN        (4),
    .FRAME_DIV  (2),
    .SERVE_DELAY(0),
    .END_HOLD   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .center     (center),
    .upd_done   (upd_done),
    .coll_l     (coll_l),
    .coll_r     (coll_r),
    .upd_req    (upd_req),
    .pos_req    (pos_req),
    .serve_dir  (serve_dir),
    .score_l    (score_l),
    .score_r    (score_r),
    .state      (state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic point(input logic r, input logic l);
    frame();
    frame();
    upd_done = 1'b1;
    coll_r   = r;
    coll_l   = l;
    cyc();
    upd_done = 1'b0;
    coll_r   = 1'b0;
    coll_l   = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    center = 1'b0;
    upd_done = 1'b0;
    coll_l = 1'b0;
    coll_r = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_req", int'(upd_req), 0);
    chk("rst_pos", int'(pos_req), 0);
    chk("rst_dir", int'(serve_dir), 0);
    chk("rst_winner", int'(winner), 0);
    rst = 1'b0;

    center = 1'b1;
    cyc();
    chk("start_state", int'(state), 1);
    chk("start_pos", int'(pos_req), 1);
    center = 1'b0;
    cyc();
    chk("play_state", int'(state), 3);
    chk("play_pos", int'(pos_req), 0);

    frame();
    chk("frame1_req", int'(upd_req), 0);
    frame();
    chk("tick1_req", int'(upd_req), 1);
    cyc(); cyc();
    chk("hold_req", int'(upd_req), 1);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    chk("done_req", int'(upd_req), 0);
    chk("done_state", int'(state), 3);
    frame();
    frame();
    chk("tick2_req", int'(upd_req), 1);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    chk("done2_req", int'(upd_req), 0);

    frame(); frame();
    frame(); frame();
    chk("overrun_hold", int'(upd_req), 1);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    chk("overrun_done", int'(upd_req), 0);
    cyc(); cyc(); cyc();
    chk("overrun_drop", int'(upd_req), 0);

    frame();
    frame();
    upd_done = 1'b1;
    coll_r = 1'b1;
    cyc();
    upd_done = 1'b0;
    coll_r = 1'b0;
    chk("pt_r_state", int'(state), 4);
    chk("pt_r_req", int'(upd_req), 0);
    cyc();
    chk("pt_r_pos_state", int'(state), 1);
    chk("pt_r_score_l", int'(score_l), 1);
    chk("pt_r_dir", int'(serve_dir), 1);
    chk("pt_r_pos_req", int'(pos_req), 1);
    cyc();
    chk("pt_r_pos_req_end", int'(pos_req), 0);
    chk("pt_r_replay", int'(state), 3);

    point(1'b0, 1'b1);
    chk("pt_l_score_r", int'(score_r), 1);
    chk("pt_l_dir", int'(serve_dir), 0);
    cyc();
    point(1'b1, 1'b1);
    chk("pt_both_score_l", int'(score_l), 2);
    chk("pt_both_score_r", int'(score_r), 1);
    cyc();

    point(1'b1, 1'b0);
    chk("l3_state", int'(state), 1);
    cyc();
    point(1'b1, 1'b0);
    chk("win_state", int'(state), 5);
    chk("win_score_l", int'(score_l), 4);
    chk("win_winner", int'(winner), 0);
    frame(); frame();
    frame(); frame();
    frame(); frame();
    chk("end_hold_state", int'(state), 5);
    cyc();
    chk("end_idle_state", int'(state), 0);
    chk("end_idle_score", int'(score_l), 4);
    center = 1'b1;
    cyc();
    chk("new_game_score", int'(score_l), 0);
    chk("new_game_dir", int'(serve_dir), 0);
    center = 1'b0;
    cyc();

    for (int i = 0; i < 3; i++) begin
      point(1'b0, 1'b1);
      cyc();
    end
    point(1'b0, 1'b1);
    chk("rwin_state", int'(state), 5);
    chk("rwin_score_r", int'(score_r), 4);
    chk("rwin_winner", int'(winner), 1);
    center = 1'b1;
    cyc();
    chk("end_edge_state", int'(state), 0);
    chk("end_edge_score", int'(score_r), 4);
    center = 1'b0;
    cyc();
    chk("idle_stay", int'(state), 0);

    center = 1'b1;
    cyc();
    center = 1'b0;
    cyc();
    point(1'b1, 1'b0);
    cyc();
    frame();
    frame();
    chk("pre_rst_req", int'(upd_req), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_req", int'(upd_req), 0);
    chk("mid_rst_score", int'(score_l), 0);
    chk("mid_rst_dir", int'(serve_dir), 0);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    frame();
    frame();
    chk("late_done_req", int'(upd_req), 0);
    chk("late_done_state", int'(state), 0);

`ifdef PONG_PAUSE_EN
    center = 1'b1;
    cyc();
    center = 1'b0;
    cyc();
    center = 1'b1;
    cyc();
    center = 1'b0;
    chk("pause_state", int'(state), 6);
    for (int i = 0; i < 10; i++) frame();
    chk("pause_req", int'(upd_req), 0);
    center = 1'b1;
    cyc();
    center = 1'b0;
    chk("resume_state", int'(state), 3);
    frame();
    frame();
    chk("resume_req", int'(upd_req), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Frame-synchronous game sequencer for the Pong datapath. It replaces the free-running divided update clocks with one clock domain: it derives game ticks from frame_start, requests exactly one ball/paddle update per tick through a req/done handshake, and owns the game state, scores, serve direction and win detection. It sits between vga_out (frame timing) and the ball/paddle update logic; drawcon reads its score outputs.

Parameters:
WIN, 4, points needed to win; must be in the range 1..15
FRAME_DIV, 1, frames per game tick; must be in the range 1..255
SERVE_DELAY, 30, ticks spent in SERVE before PLAY; 0 is legal
END_HOLD, 120, ticks spent in END before auto-return to IDLE

Ports:
clk  in  1  pixel-domain clock
rst  in  1  reset: synchronous, active-high
frame_start  in  1  one-cycle pulse at the start of vertical blanking
center  in  1  start button, already debounced, level
upd_done  in  1  datapath finished the current update; coll_l and coll_r are valid in the same cycle
coll_l  in  1  ball passed the left edge
coll_r  in  1  ball passed the right edge
upd_req  out  1  request one ball/paddle update
pos_req  out  1  one-cycle pulse: load serve positions
serve_dir  out  1  0 = ball moves right, 1 = ball moves left
score_l  out  4  left score
score_r  out  4  right score
state  out  3  encoded game state
winner  out  1  0 = left, 1 = right; valid in END

Behaviour:
- Reset: state=IDLE, upd_req=0, pos_req=0, serve_dir=0, scores=0, winner=0, all counters=0. Reset mid-handshake drops upd_req the next cycle; a later upd_done is ignored.
- Tick generation
  - frame_cnt (8 bit) increments on each frame_start.
  - When frame_cnt==FRAME_DIV-1 and frame_start=1: tick=1 for one cycle, and frame_cnt wraps to 0.
  - frame_cnt runs in every state.
- State encoding: IDLE=0, POSITION=1, SERVE=2, PLAY=3, POINT=4, END=5. Any other value goes to IDLE.
- IDLE: on center=1, clear both scores, set serve_dir=0, go to POSITION.
- POSITION: lasts exactly 1 cycle. pos_req=1 during this cycle. Next state is SERVE, and serve_cnt is cleared.
- SERVE
  - Each tick increments serve_cnt.
  - Go to PLAY in the cycle where serve_cnt==SERVE_DELAY, checked before the increment.
  - With SERVE_DELAY=0, PLAY is entered the cycle after POSITION.
- PLAY
  - A tick with upd_req=0 sets upd_req=1 on the next cycle.
  - upd_req holds until upd_done is sampled 1, then clears the next cycle. Latency from tick to upd_req is 1 cycle.
  - A tick that arrives while upd_req=1 is dropped (overrun); the handshake is not disturbed.
  - upd_done while upd_req=0 is ignored.
  - On upd_done with coll_l=0 and coll_r=0: stay in PLAY.
  - On upd_done with coll_r=1 or coll_l=1: go to POINT, latching which side collided. If both are 1, coll_r has priority.
- POINT: lasts 1 cycle.
  - coll_r: score_l+1, serve_dir=1.
  - coll_l: score_r+1, serve_dir=0.
  - If the incremented score equals WIN: set winner, clear end_cnt, go to END. Otherwise go to POSITION.
  - Scores never exceed WIN (saturating).
- END
  - Each tick increments end_cnt.
  - Go to IDLE when end_cnt==END_HOLD, or immediately on a rising edge of center. Scores hold until the next game starts.
- center rising edge is detected with a registered copy of center. Only the rising edge is used in END; the level is used in IDLE.
- All outputs are registered.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- When defined:
  - A rising edge of center in PLAY toggles a pause flag.
  - While paused, ticks are ignored and no new upd_req is issued. An in-flight handshake still completes, and its collision result is still processed.
  - state output reads 6 (PAUSE) while paused.
  - The flag clears on reset and on leaving PLAY.
- When undefined: center is ignored in PLAY, and the state value 6 never appears.

Decomposition:
- Shared package pong_pkg holds:
  - the state encoding constants (IDLE..END, PAUSE=6);
  - the serve_dir encodings DIR_RIGHT=0 and DIR_LEFT=1;
  - the score width of 4.
- One natural sub-module is pong_tick_gen: frame_start divider that produces tick. It is parameterised by FRAME_DIV and takes clk/rst.

Test Plan:
1. Tick and handshake: FRAME_DIV=2, SERVE_DELAY=0; press center; 4 frame_start pulses -> 2 ticks; upd_req rises 1 cycle after each tick; upd_done after 3 cycles -> upd_req low next cycle.
2. Overrun: hold upd_done low across 2 ticks -> upd_req stays high continuously; a single upd_done -> exactly one completed update, and the second tick is dropped.
3. Scoring: return upd_done with coll_r=1 -> POINT, then POSITION; score_l=1, serve_dir=1, pos_req high for exactly 1 cycle. Same with coll_l=1 -> score_r=1, serve_dir=0. Both set -> score_l increments only.
4. Win: WIN=4; four coll_r events -> score_l=4, state=END, winner=0. After END_HOLD=3 ticks -> IDLE with score_l still 4. Next center -> scores 0.
5. Reset: assert rst while upd_req=1 in PLAY -> next cycle state=IDLE, upd_req=0, scores=0; a late upd_done does not start an update.
6. Pause (PONG_PAUSE_EN): center edge in PLAY -> state=6; 5 ticks produce no upd_req; a second edge -> state=3, and the next tick issues upd_req.
